rot_dma_sched: RTL and testbench

Tile scheduler that sequences the rotate DMA datapath: AHB read bursts, the in-buffer to out-buffer pixel shuffle, and AHB write bursts.
- Processes an image as I_NUM_TILES tiles of BURST_LEN 32-bit words.
- Per tile: one read burst into the input buffer, then a word-reversing shuffle into the output buffer, then one write burst.
- Source tiles are walked upward and destination tiles downward, which gives a 180° rotation at tile and word granularity.
- Sits between the register/control front end and the DMA core; drives the DMA core's start/size/addr/count/write command inputs.

---
 rtl/rot_pkg.sv | 21 ++
 rtl/rot_dma_sched_if.sv | 33 +++
 rtl/rot_tile_addr_gen.sv | 63 ++++++
 rtl/rot_dma_sched.sv | 184 ++++++++++++++++++
 tb/tb_rot_dma_sched.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rot_pkg.sv
// rtl/rot_pkg.sv - shared types and constants for the rotate DMA tile scheduler
// Purpose: scheduler state encoding, AHB word size code, byte/word ratio, default burst length.
// Ports: none (package).
package rot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_SHUF    = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_WR_WAIT = 3'd5,
        ST_NEXT    = 3'd6,
        ST_FIN     = 3'd7
    } state_t;

    localparam logic [2:0] HSIZE_WORD        = 3'b010;
    localparam int         BYTES_PER_WORD    = 4;
    localparam int         DEFAULT_BURST_LEN = 16;

endpackage

// File: rtl/rot_dma_sched_if.sv
// rtl/rot_dma_sched_if.sv - command/response bundle between the tile scheduler and the DMA core
// Purpose: groups the burst command outputs and the burst-complete pulse.
// Ports (signals): O_START, O_ADDR[31:0], O_COUNT[4:0], O_SIZE[2:0], O_WRITE (scheduler -> DMA core),
//                  I_DMA_DONE (DMA core -> scheduler).
// Modports: master = scheduler side, slave = DMA core side.
interface rot_dma_sched_if;

    logic        O_START;
    logic [31:0] O_ADDR;
    logic [4:0]  O_COUNT;
    logic [2:0]  O_SIZE;
    logic        O_WRITE;
    logic        I_DMA_DONE;

    modport master (
        output O_START,
        output O_ADDR,
        output O_COUNT,
        output O_SIZE,
        output O_WRITE,
        input  I_DMA_DONE
    );

    modport slave (
        input  O_START,
        input  O_ADDR,
        input  O_COUNT,
        input  O_SIZE,
        input  O_WRITE,
        output I_DMA_DONE
    );

endinterface

// File: rtl/rot_tile_addr_gen.sv
// rtl/rot_tile_addr_gen.sv - source/destination tile pointers and remaining-tile count
// Purpose: loads the job pointers, steps source up and destination down one tile per step,
//          and flags when the current tile is the last one.
// Ports: clk_i, rst_i (async active-high), load_i, step_i, src_base_i[31:0], dst_last_i[31:0],
//        num_tiles_i[TILE_W-1:0] -> src_ptr_o[31:0], dst_ptr_o[31:0], last_o.
module rot_tile_addr_gen
    import rot_pkg::*;
#(
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int TILE_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [31:0]       src_base_i,
    input  logic [31:0]       dst_last_i,
    input  logic [TILE_W-1:0] num_tiles_i,
    output logic [31:0]       src_ptr_o,
    output logic [31:0]       dst_ptr_o,
    output logic              last_o
);

    localparam logic [31:0] TILE_BYTES = 32'(BYTES_PER_WORD * BURST_LEN);

    logic [31:0]       src_q, src_d;
    logic [31:0]       dst_q, dst_d;
    logic [TILE_W-1:0] rem_q, rem_d;

    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        rem_d = rem_q;
        if (load_i) begin
            src_d = src_base_i;
            dst_d = dst_last_i;
            rem_d = num_tiles_i;
        end else if (step_i) begin
            // Pointer arithmetic wraps naturally modulo 2^32.
            src_d = src_q + TILE_BYTES;
            dst_d = dst_q - TILE_BYTES;
            rem_d = rem_q - TILE_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q <= '0;
            dst_q <= '0;
            rem_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            rem_q <= rem_d;
        end
    end

    assign src_ptr_o = src_q;
    assign dst_ptr_o = dst_q;
    // Sampled in NEXT before the decrement: one tile left means the job ends after this step.
    assign last_o    = (rem_q == TILE_W'(1));

endmodule

// File: rtl/rot_dma_sched.sv
// rtl/rot_dma_sched.sv - tile scheduler for the rotate DMA: read burst, word-reversing shuffle, write burst
// Purpose: walks source tiles upward and destination tiles downward, giving a 180 degree rotation.
// Optional feature macro: ROT_DMA_SCHED_TIMEOUT_EN (wait-state timeout driving the sticky O_ERR).
// Ports: I_HCLK, I_HRESET (async active-high), I_GO, I_SRC_BASE[31:0], I_DST_LAST[31:0],
//        I_NUM_TILES[TILE_W-1:0], dma (rot_dma_sched_if.master: O_START/O_ADDR/O_COUNT/O_SIZE/O_WRITE/I_DMA_DONE),
//        O_BUF_XFER_EN, O_BUF_RD_ADDR[7:0], O_BUF_WR_ADDR[7:0], O_BUSY, O_DONE, O_ERR.
module rot_dma_sched
    import rot_pkg::*;
#(
    parameter int BURST_LEN   = DEFAULT_BURST_LEN,
    parameter int TILE_W      = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 I_HCLK,
    input  logic                 I_HRESET,
    input  logic                 I_GO,
    input  logic [31:0]          I_SRC_BASE,
    input  logic [31:0]          I_DST_LAST,
    input  logic [TILE_W-1:0]    I_NUM_TILES,
    rot_dma_sched_if.master      dma,
    output logic                 O_BUF_XFER_EN,
    output logic [7:0]           O_BUF_RD_ADDR,
    output logic [7:0]           O_BUF_WR_ADDR,
    output logic                 O_BUSY,
    output logic                 O_DONE,
    output logic                 O_ERR
);

    localparam logic [7:0] SHUF_LAST = 8'(BURST_LEN - 1);

    state_t      state_q;
    logic [7:0]  shuf_k_q;
    logic        start_q;
    logic [31:0] addr_q;
    logic        write_q;
    logic        xfer_q;
    logic [7:0]  rd_addr_q;
    logic [7:0]  wr_addr_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [31:0] src_ptr;
    logic [31:0] dst_ptr;
    logic        last_tile;
    logic        load;
    logic        step;

    assign load = (state_q == ST_IDLE) && I_GO;
    assign step = (state_q == ST_NEXT);

    rot_tile_addr_gen #(
        .BURST_LEN (BURST_LEN),
        .TILE_W    (TILE_W)
    ) u_addr_gen (
        .clk_i       (I_HCLK),
        .rst_i       (I_HRESET),
        .load_i      (load),
        .step_i      (step),
        .src_base_i  (I_SRC_BASE),
        .dst_last_i  (I_DST_LAST),
        .num_tiles_i (I_NUM_TILES),
        .src_ptr_o   (src_ptr),
        .dst_ptr_o   (dst_ptr),
        .last_o      (last_tile)
    );

`ifdef ROT_DMA_SCHED_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] wait_cnt_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            state_q   <= ST_IDLE;
            shuf_k_q  <= '0;
            start_q   <= 1'b0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            xfer_q    <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef ROT_DMA_SCHED_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            // Outputs are registered decodes of the current state, so every strobe
            // trails its state by one cycle; the whole sequence shifts uniformly.
            start_q   <= (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
            xfer_q    <= (state_q == ST_SHUF);
            rd_addr_q <= (state_q == ST_SHUF) ? shuf_k_q : 8'd0;
            wr_addr_q <= (state_q == ST_SHUF) ? (SHUF_LAST - shuf_k_q) : 8'd0;
            busy_q    <= (state_q != ST_IDLE);
            done_q    <= (state_q == ST_FIN);

            case (state_q)
                ST_IDLE: begin
                    if (I_GO) begin
                        err_q   <= 1'b0;
                        state_q <= (I_NUM_TILES == '0) ? ST_FIN : ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    addr_q  <= src_ptr;
                    write_q <= 1'b0;
                    state_q <= ST_RD_WAIT;
`ifdef ROT_DMA_SCHED_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                ST_RD_WAIT: begin
                    if (dma.I_DMA_DONE) begin
                        shuf_k_q <= '0;
                        state_q  <= ST_SHUF;
                    end
`ifdef ROT_DMA_SCHED_TIMEOUT_EN
                    else if (wait_cnt_q == TIMEOUT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
`endif
                end
                ST_SHUF: begin
                    shuf_k_q <= shuf_k_q + 8'd1;
                    if (shuf_k_q == SHUF_LAST) begin
                        state_q <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    addr_q  <= dst_ptr;
                    write_q <= 1'b1;
                    state_q <= ST_WR_WAIT;
`ifdef ROT_DMA_SCHED_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                ST_WR_WAIT: begin
                    if (dma.I_DMA_DONE) begin
                        state_q <= ST_NEXT;
                    end
`ifdef ROT_DMA_SCHED_TIMEOUT_EN
                    else if (wait_cnt_q == TIMEOUT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
`endif
                end
                ST_NEXT: begin
                    state_q <= last_tile ? ST_FIN : ST_RD_REQ;
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dma.O_START = start_q;
    assign dma.O_ADDR  = addr_q;
    assign dma.O_COUNT = 5'(BURST_LEN);
    assign dma.O_SIZE  = HSIZE_WORD;
    assign dma.O_WRITE = write_q;

    assign O_BUF_XFER_EN = xfer_q;
    assign O_BUF_RD_ADDR = rd_addr_q;
    assign O_BUF_WR_ADDR = wr_addr_q;
    assign O_BUSY        = busy_q;
    assign O_DONE        = done_q;
    assign O_ERR         = err_q;

endmodule

// File: tb/tb_rot_dma_sched.sv
// tb/tb_rot_dma_sched.sv - directed self-checking bench for rot_dma_sched
module tb_rot_dma_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] ntiles = '0;
    logic        xfer;
    logic [7:0]  rd_a;
    logic [7:0]  wr_a;
    logic        busy;
    logic        done;
    logic        err;

    logic        dma_en = 1'b1;
    logic        resp_done;
    logic        spur_done = 1'b0;
    int          resp_cnt;

    int vectors = 0;
    int miscompares = 0;

    int          n_starts = 0;
    int          n_shuf = 0;
    int          n_done = 0;
    int          consec_starts = 0;
    logic        prev_start = 1'b0;
    logic [31:0] st_addr [0:63];
    logic        st_wr   [0:63];
    logic [7:0]  sh_rd   [0:15];
    logic [7:0]  sh_wr   [0:15];

    logic [31:0] exp_addr [0:5];

    rot_dma_sched_if dma_if ();

    assign dma_if.I_DMA_DONE = resp_done | spur_done;

    rot_dma_sched #(
        .BURST_LEN   (16),
        .TILE_W      (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .I_HCLK        (clk),
        .I_HRESET      (rst),
        .I_GO          (go),
        .I_SRC_BASE    (src),
        .I_DST_LAST    (dst),
        .I_NUM_TILES   (ntiles),
        .dma           (dma_if),
        .O_BUF_XFER_EN (xfer),
        .O_BUF_RD_ADDR (rd_a),
        .O_BUF_WR_ADDR (wr_a),
        .O_BUSY        (busy),
        .O_DONE        (done),
        .O_ERR         (err)
    );

    always #5 clk = ~clk;

    // DMA core model: completes each burst 5 cycles after it sees O_START.
    initial begin
        resp_done = 1'b0;
        resp_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            resp_done = 1'b0;
            if (resp_cnt != 0) begin
                resp_cnt--;
                if (resp_cnt == 0) resp_done = 1'b1;
            end
            if (dma_en && dma_if.O_START) resp_cnt = 5;
        end
    end

    always @(negedge clk) begin
        if (dma_if.O_START === 1'b1) begin
            if (prev_start) consec_starts++;
            if (n_starts < 64) begin
                st_addr[n_starts] = dma_if.O_ADDR;
                st_wr[n_starts] = dma_if.O_WRITE;
            end
            n_starts++;
        end
        prev_start = (dma_if.O_START === 1'b1);
        if (xfer === 1'b1) begin
            if (n_shuf < 16) begin
                sh_rd[n_shuf] = rd_a;
                sh_wr[n_shuf] = wr_a;
            end
            n_shuf++;
        end
        if (done === 1'b1) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        src = s;
        dst = d;
        ntiles = n;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && n_done < target; i++) tick();
        chk(tag, n_done, target);
    endtask

    task automatic wait_start(input int budget, input string tag);
        for (int i = 0; i < budget && dma_if.O_START !== 1'b1; i++) tick();
        chk(tag, dma_if.O_START, 1'b1);
    endtask

    task automatic wait_xfer(input int budget, input string tag);
        for (int i = 0; i < budget && xfer !== 1'b1; i++) tick();
        chk(tag, xfer, 1'b1);
    endtask

    task automatic check_three(input int base, input string tag);
        chk({tag, "_nstarts"}, n_starts - base, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), st_addr[base + i], exp_addr[i]);
            chk($sformatf("%s_wr%0d", tag, i), st_wr[base + i], i % 2);
        end
    endtask

    initial begin
        int base;
        int dbase;

        exp_addr = '{32'h0000_1000, 32'h0000_8000, 32'h0000_1040,
                     32'h0000_7FC0, 32'h0000_1080, 32'h0000_7F80};

        // Reset values
        tick();
        tick();
        chk("rst_start", dma_if.O_START, 1'b0);
        chk("rst_addr", dma_if.O_ADDR, 32'h0);
        chk("rst_count", dma_if.O_COUNT, 5'd16);
        chk("rst_size", dma_if.O_SIZE, 3'b010);
        chk("rst_write", dma_if.O_WRITE, 1'b0);
        chk("rst_xfer", xfer, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        // Single tile
        base = n_starts;
        dbase = n_done;
        start_job(32'h1000, 32'h8000, 16'd1);
        wait_done(dbase + 1, 200, "t1_done_seen");
        tick();
        tick();
        chk("t1_nstarts", n_starts - base, 2);
        chk("t1_rd_addr", st_addr[base], 32'h1000);
        chk("t1_rd_wr", st_wr[base], 1'b0);
        chk("t1_wr_addr", st_addr[base + 1], 32'h8000);
        chk("t1_wr_wr", st_wr[base + 1], 1'b1);
        chk("t1_nshuf", n_shuf, 16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t1_shuf_rd%0d", k), sh_rd[k], k);
            chk($sformatf("t1_shuf_wr%0d", k), sh_wr[k], 15 - k);
        end
        chk("t1_ndone", n_done - dbase, 1);
        chk("t1_busy", busy, 1'b0);

        // Three tiles
        base = n_starts;
        dbase = n_done;
        start_job(32'h1000, 32'h8000, 16'd3);
        wait_done(dbase + 1, 400, "t2_done_seen");
        tick();
        tick();
        check_three(base, "t2");
        chk("t2_ndone", n_done - dbase, 1);
        chk("t2_busy", busy, 1'b0);

        // Empty job: O_DONE two cycles after I_GO
        base = n_starts;
        dbase = n_done;
        ntiles = 16'd0;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("t3_done_c1", done, 1'b0);
        tick();
        chk("t3_done_c2", done, 1'b1);
        tick();
        chk("t3_done_c3", done, 1'b0);
        tick();
        chk("t3_nstarts", n_starts - base, 0);
        chk("t3_ndone", n_done - dbase, 1);

        // I_GO during RD_WAIT and spurious I_DMA_DONE during SHUF
        base = n_starts;
        dbase = n_done;
        start_job(32'h1000, 32'h8000, 16'd3);
        wait_start(20, "t4_first_start");
        src = 32'hDEAD_0000;
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_xfer(50, "t4_shuf_seen");
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        wait_done(dbase + 1, 400, "t4_done_seen");
        tick();
        tick();
        check_three(base, "t4");
        chk("t4_ndone", n_done - dbase, 1);
        chk("t4_busy", busy, 1'b0);

        // Reset during SHUF
        dbase = n_done;
        start_job(32'h1000, 32'h8000, 16'd3);
        wait_xfer(50, "t5_shuf_seen");
        #3;
        rst = 1'b1;
        #1;
        chk("t5_rst_xfer", xfer, 1'b0);
        chk("t5_rst_rd", rd_a, 8'd0);
        chk("t5_rst_wr", wr_a, 8'd0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_addr", dma_if.O_ADDR, 32'h0);
        chk("t5_rst_count", dma_if.O_COUNT, 5'd16);
        chk("t5_rst_size", dma_if.O_SIZE, 3'b010);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t5_no_done", n_done - dbase, 0);
        base = n_starts;
        dbase = n_done;
        start_job(32'h2000, 32'h9000, 16'd1);
        wait_done(dbase + 1, 200, "t5_done_seen");
        chk("t5_rd_addr", st_addr[base], 32'h2000);
        chk("t5_rd_wr", st_wr[base], 1'b0);
        chk("t5_wr_addr", st_addr[base + 1], 32'h9000);
        chk("t5_wr_wr", st_wr[base + 1], 1'b1);

`ifdef ROT_DMA_SCHED_TIMEOUT_EN
        // Timeout with I_DMA_DONE withheld
        tick();
        dbase = n_done;
        dma_en = 1'b0;
        start_job(32'h3000, 32'h8000, 16'd1);
        wait_start(10, "t6_start_seen");
        for (int i = 0; i < 7; i++) tick();
        chk("t6_err_before", err, 1'b0);
        tick();
        chk("t6_err_set", err, 1'b1);
        tick();
        chk("t6_busy", busy, 1'b0);
        tick();
        chk("t6_err_sticky", err, 1'b1);
        chk("t6_no_done", n_done - dbase, 0);
        dma_en = 1'b1;
        ntiles = 16'd0;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("t6_err_clear", err, 1'b0);
        tick();
        tick();
`endif

        chk("start_not_back_to_back", consec_starts, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
